// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame buffer write side: FSM state encodings and
// the position of the bank-select bit inside a memory address.
package frame_buf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The bank select is the address MSB; the bits below it index the pixel.
  function automatic int bank_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/frame_wr_ctrl.sv
// Write-side controller for a ping-pong frame buffer: turns a pixel stream into
// registered memory writes and publishes the bank holding the last full frame.
module frame_wr_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int FRAME_PIXELS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_bank,
  output logic                  rd_valid,
  output logic                  frame_done,
  output logic                  sync_err
);
  import frame_buf_pkg::*;

  localparam int IDX_W    = ADDR_WIDTH - 1;
  localparam int BANK_BIT = bank_bit(ADDR_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]            state_q, state_d;
  logic                  bank_q, bank_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic bank,
                                                      input logic [IDX_W-1:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    a                 = '0;
    a[BANK_BIT]       = bank;
    a[BANK_BIT-1:0]   = idx;
    return a;
  endfunction

  assign in_ready = (state_q != ST_DONE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    idx_d      = idx_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Beats before the first start-of-frame are dropped silently.
        if (accept && in_sof) begin
          wr_en_d = 1'b1;
          addr_d  = make_addr(bank_q, '0);
          data_d  = in_data;
          idx_d   = IDX_ONE;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          wr_en_d = 1'b1;
          data_d  = in_data;
          if (in_sof) begin
            // Early sof restarts the frame in the same bank; rd_bank is untouched.
            err_d  = 1'b1;
            addr_d = make_addr(bank_q, '0);
            idx_d  = IDX_ONE;
          end else begin
            addr_d = make_addr(bank_q, idx_q);
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        // The last write is already committed, so the finished bank can be published.
        bank_d     = ~bank_q;
        rd_bank_d  = bank_q;
        rd_valid_d = 1'b1;
        idx_d      = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_bank_q  <= 1'b1;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      idx_q      <= idx_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign rd_bank    = rd_bank_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Bench for frame_wr_ctrl: a vector table for the first frame, directed corner
// sequences, then random traffic against a frame-level reference model.
module tb_frame_wr_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int FP = 8;
  localparam int BANK_SPAN = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic          in_ready, wr_en, rd_bank, rd_valid, frame_done, sync_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  frame_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .rd_valid(rd_valid),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is either in progress (count pixels so far) or not;
  // after a completed frame the controller takes one pause cycle to swap banks.
  bit m_in_frame, m_pause, m_bank, m_rd_bank, m_rd_valid;
  int m_count;
  bit e_en, e_done, e_err;
  int e_addr, e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_pause = 0; m_bank = 0; m_rd_bank = 1; m_rd_valid = 0;
    m_count = 0; e_en = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_edge(input bit v, input bit s, input int d);
    bit acc;
    acc = v && !m_pause;
    e_en = 0; e_done = 0; e_err = 0;
    if (m_pause) begin
      m_rd_bank  = m_bank;
      m_bank     = !m_bank;
      m_rd_valid = 1;
      m_pause    = 0;
      m_count    = 0;
    end else if (acc && s) begin
      e_err = m_in_frame;
      e_en = 1; e_addr = m_bank * BANK_SPAN; e_data = d;
      m_in_frame = 1; m_count = 1;
    end else if (acc && m_in_frame) begin
      e_en = 1; e_addr = m_bank * BANK_SPAN + m_count; e_data = d;
      m_count++;
      if (m_count == FP) begin
        e_done = 1; m_pause = 1; m_in_frame = 0;
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = d;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_pause));
    @(posedge clk);
    model_edge(v, s, int'(d));
    #1;
    chk("wr_en", 32'(wr_en), 32'(e_en));
    if (e_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("sync_err", 32'(sync_err), 32'(e_err));
    chk("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
  endtask

  typedef struct {
    bit v; bit s; logic [DW-1:0] d;
    bit rdy; bit en; int addr; int data; bit done; bit rdb; bit rdv;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    model_reset();

    // Basic frame from reset: pixels 1..8, then a beat offered during the pause.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{v:1, s:(i == 0), d:DW'(i + 1), rdy:1, en:1, addr:i, data:i + 1,
                 done:(i == 7), rdb:1, rdv:0};
    tbl[8] = '{v:1, s:1, d:16'h0099, rdy:0, en:0, addr:0, data:0, done:0, rdb:0, rdv:1};
    tbl[9] = '{v:0, s:0, d:16'h0000, rdy:1, en:0, addr:0, data:0, done:0, rdb:0, rdv:1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rd_bank", 32'(rd_bank), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(sync_err), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      chk("tbl_en", 32'(wr_en), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk("tbl_addr", 32'(wr_addr), 32'(tbl[i].addr));
        chk("tbl_data", 32'(wr_data), 32'(tbl[i].data));
      end
      chk("tbl_done", 32'(frame_done), 32'(tbl[i].done));
      chk("tbl_rd_bank", 32'(rd_bank), 32'(tbl[i].rdb));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].rdv));
    end

    // Pre-sync discard, then a frame that lands in bank 1 with gaps.
    step(1, 0, 16'h00AA); chk("discard_AA", 32'(wr_en), 0);
    step(1, 0, 16'h00AB); chk("discard_AB", 32'(wr_en), 0);
    step(1, 0, 16'h00AC); chk("discard_AC", 32'(wr_en), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), DW'(16'h0200 + i));
      chk("pp_addr", 32'(wr_addr), 32'(8 + i));
      step(0, 0, 16'hDEAD);
      chk("gap_no_write", 32'(wr_en), 0);
    end
    step(0, 0, 16'h0000);
    chk("pingpong_rd_bank", 32'(rd_bank), 1);

    // Early sof: 4 beats, restart with 55, then 7 beats to complete the frame.
    for (int i = 0; i < 4; i++) step(1, (i == 0), DW'(16'h0300 + i));
    step(1, 1, 16'h0055);
    chk("early_sof_err", 32'(sync_err), 1);
    chk("early_sof_addr", 32'(wr_addr), 0);
    chk("early_sof_data", 32'(wr_data), 32'h55);
    chk("early_sof_rd_bank", 32'(rd_bank), 1);
    for (int i = 1; i < 8; i++) step(1, 0, DW'(16'h0400 + i));
    chk("early_done", 32'(frame_done), 1);
    chk("early_done_addr", 32'(wr_addr), 7);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    chk("early_rd_bank_after", 32'(rd_bank), 0);

    // Reset mid-frame after 5 beats in bank 1.
    for (int i = 0; i < 5; i++) step(1, (i == 0), DW'(16'h0500 + i));
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_rd_bank", 32'(rd_bank), 1);
    @(negedge clk) reset = 1'b1;
    step(1, 1, 16'h0600);
    chk("post_rst_addr", 32'(wr_addr), 0);
    chk("post_rst_en", 32'(wr_en), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           DW'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
